// File: rtl/counter5_ctrl_pkg.sv
// Shared constants for the counter5 control stage: reset values and the
// direction encoding seen by the downstream counter.
package counter5_ctrl_pkg;

    localparam logic DIR_UP      = 1'b1;
    localparam logic DIR_DOWN    = 1'b0;

    localparam logic RST_ENABLE  = 1'b0;
    localparam logic RST_UPDOWN  = DIR_UP;
    localparam logic RST_RUNNING = 1'b0;

    // One accepted rising edge per button, grouped for the control register.
    typedef struct packed {
        logic run;
        logic dir;
        logic step;
    } btn_evt_t;

endpackage

// File: rtl/btn_debounce.sv
// Synchronise, debounce and rising-edge detect one raw pushbutton.
// A level change is accepted once the synchronised sample has differed from
// the stable level for DEBOUNCE_CYCLES consecutive edges.
// press_nxt is the accept strobe for a rising level. It is high during the
// cycle that ends on the accepting edge, so a consumer can act on that same
// edge. press is the registered one-cycle pulse that follows it.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int DB_W            = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press,
    output logic press_nxt
);

    localparam logic [DB_W-1:0] LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            r_s1;
    logic            r_s2;
    logic            r_stable;
    logic            r_press;
    logic [DB_W-1:0] r_cnt;

    logic            w_diff;
    logic            w_done;

    assign w_diff    = (r_s2 != r_stable);
    assign w_done    = w_diff && (r_cnt == LAST);
    assign press_nxt = w_done & r_s2;
    assign level     = r_stable;
    assign press     = r_press;

    // Two-flop synchroniser, mismatch counter and accepted level.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_s1     <= 1'b0;
            r_s2     <= 1'b0;
            r_stable <= 1'b0;
            r_press  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_s1    <= raw;
            r_s2    <= r_s1;
            r_press <= press_nxt;
            if (!w_diff) begin
                r_cnt <= '0;
            end else if (w_done) begin
                r_stable <= r_s2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/counter5_ctrl.sv
// Control stage for the 5-bit up/down counter: three debounced buttons drive
// a small run/direction register whose outputs feed the counter directly.
module counter5_ctrl
    import counter5_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int DB_W            = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_run,
    input  logic btn_dir,
    input  logic btn_step,
    output logic enable,
    output logic updown,
    output logic running
);

    btn_evt_t w_evt;
    btn_evt_t w_lvl;
    btn_evt_t w_prs;
    logic     w_unused_dbg;
    logic     w_next_running;

    logic     r_enable;
    logic     r_updown;
    logic     r_running;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_db_run (
        .clk(clk), .reset(reset), .raw(btn_run),
        .level(w_lvl.run), .press(w_prs.run), .press_nxt(w_evt.run)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_db_dir (
        .clk(clk), .reset(reset), .raw(btn_dir),
        .level(w_lvl.dir), .press(w_prs.dir), .press_nxt(w_evt.dir)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_db_step (
        .clk(clk), .reset(reset), .raw(btn_step),
        .level(w_lvl.step), .press(w_prs.step), .press_nxt(w_evt.step)
    );

    // Stable levels and registered pulses are debug taps only.
    assign w_unused_dbg   = ^{w_lvl, w_prs};

    assign w_next_running = r_running ^ w_evt.run;

    // Run/direction state; a step while stopped gives a single enable cycle,
    // and a simultaneous run press absorbs the step.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_enable  <= RST_ENABLE;
            r_updown  <= RST_UPDOWN;
            r_running <= RST_RUNNING;
        end else begin
            r_running <= w_next_running;
            if (w_evt.dir)
                r_updown <= ~r_updown;
            r_enable  <= w_next_running | (w_evt.step & ~r_running & ~w_evt.run);
        end
    end

    assign enable  = r_enable;
    assign updown  = r_updown;
    assign running = r_running;

endmodule

// File: tb/tb_counter5_ctrl.sv
module tb_counter5_ctrl;

    localparam int DC = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic btn_run = 1'b0;
    logic btn_dir = 1'b0;
    logic btn_step = 1'b0;
    wire  enable, updown, running;

    int checks = 0;
    int errors = 0;

    // Reference model: history of raw samples and of synchronised samples per
    // button; a level is accepted when the last DC synchronised samples all
    // disagree with the accepted level.
    bit   rawq [3][$];
    bit   sq   [3][$];
    bit   m_stable [3];
    bit   m_run = 1'b0;
    bit   m_up  = 1'b1;
    bit   m_en  = 1'b0;

    counter5_ctrl #(.DEBOUNCE_CYCLES(DC), .DB_W(20)) dut (
        .clk(clk), .reset(reset), .btn_run(btn_run), .btn_dir(btn_dir),
        .btn_step(btn_step), .enable(enable), .updown(updown), .running(running)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit rst_n, input bit r, input bit d, input bit s);
        bit acc [3];
        bit raw [3];
        bit runp, dirp, stepp, nrun, all_diff, sv;
        int n;
        raw[0] = r; raw[1] = d; raw[2] = s;
        if (!rst_n) begin
            for (int b = 0; b < 3; b++) begin
                rawq[b].delete();
                sq[b].delete();
                m_stable[b] = 1'b0;
            end
            m_run = 1'b0; m_up = 1'b1; m_en = 1'b0;
            return;
        end
        for (int b = 0; b < 3; b++) begin
            rawq[b].push_back(raw[b]);
            n  = rawq[b].size();
            sv = (n >= 3) ? rawq[b][n-3] : 1'b0;
            sq[b].push_back(sv);
            if (rawq[b].size() > 8) void'(rawq[b].pop_front());
            if (sq[b].size() > 8)   void'(sq[b].pop_front());
            acc[b] = 1'b0;
            n = sq[b].size();
            if (n >= DC) begin
                all_diff = 1'b1;
                for (int j = n - DC; j < n; j++)
                    if (sq[b][j] == m_stable[b]) all_diff = 1'b0;
                if (all_diff) begin
                    m_stable[b] = sv;
                    acc[b] = sv;
                end
            end
        end
        runp = acc[0]; dirp = acc[1]; stepp = acc[2];
        nrun = m_run ^ runp;
        m_en = nrun | (stepp & ~m_run & ~runp);
        if (dirp) m_up = ~m_up;
        m_run = nrun;
    endtask

    // One clock: drive inputs, clock the model, compare just after the edge.
    task automatic tick(input bit rst_n, input bit r, input bit d, input bit s);
        reset = rst_n; btn_run = r; btn_dir = d; btn_step = s;
        @(posedge clk);
        model_edge(rst_n, r, d, s);
        #1;
        chk("enable",  {31'b0, enable},  {31'b0, m_en});
        chk("updown",  {31'b0, updown},  {31'b0, m_up});
        chk("running", {31'b0, running}, {31'b0, m_run});
    endtask

    int en_cnt;
    int hold [3];
    bit lvl  [3];

    initial begin
        // Reset with every button pressed.
        #2;
        tick(0, 1, 1, 1);
        chk("rst_enable", {31'b0, enable}, 0);
        chk("rst_updown", {31'b0, updown}, 1);
        chk("rst_running", {31'b0, running}, 0);
        tick(0, 1, 1, 1);
        chk("rst2_running", {31'b0, running}, 0);
        for (int i = 0; i < 8; i++) tick(1, 0, 0, 0);

        // Run press: running from the DC+1'th edge after the first sample.
        for (int i = 0; i < 10; i++) begin
            tick(1, 1, 0, 0);
            if (i == DC)     chk("run_lat_pre",  {31'b0, running}, 0);
            if (i == DC + 1) chk("run_lat_post", {31'b0, running}, 1);
            if (i == DC + 1) chk("run_enable",   {31'b0, enable},  1);
        end
        for (int i = 0; i < 10; i++) tick(1, 0, 0, 0);
        chk("run_hold", {31'b0, running}, 1);
        for (int i = 0; i < 10; i++) begin
            tick(1, 1, 0, 0);
            if (i == DC + 1) chk("stop_lat", {31'b0, running}, 0);
        end
        for (int i = 0; i < 10; i++) tick(1, 0, 0, 0);

        // Short direction glitch is filtered, long one toggles.
        for (int i = 0; i < 3; i++) tick(1, 0, 1, 0);
        for (int i = 0; i < 8; i++) tick(1, 0, 0, 0);
        chk("dir_glitch", {31'b0, updown}, 1);
        for (int i = 0; i < 8; i++) begin
            tick(1, 0, 1, 0);
            if (i == DC)     chk("dir_pre",  {31'b0, updown}, 1);
            if (i == DC + 1) chk("dir_post", {31'b0, updown}, 0);
        end
        for (int i = 0; i < 10; i++) tick(1, 0, 0, 0);

        // Single step while stopped: exactly one enable cycle.
        en_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick(1, 0, 0, 1);
            en_cnt += int'(enable);
        end
        for (int i = 0; i < 10; i++) begin
            tick(1, 0, 0, 0);
            en_cnt += int'(enable);
        end
        chk("step_once", en_cnt, 1);

        // Run and step together: run wins, enable stays high.
        for (int i = 0; i < 10; i++) tick(1, 1, 0, 1);
        for (int i = 0; i < 6; i++)  tick(1, 0, 0, 0);
        chk("runstep_run", {31'b0, running}, 1);
        chk("runstep_en",  {31'b0, enable},  1);
        for (int i = 0; i < 10; i++) tick(1, 0, 0, 1);
        for (int i = 0; i < 6; i++)  tick(1, 0, 0, 0);
        chk("step_ignored", {31'b0, enable}, 1);
        for (int i = 0; i < 8; i++)  tick(1, 1, 0, 0);
        for (int i = 0; i < 8; i++)  tick(1, 0, 0, 0);
        chk("stopped_again", {31'b0, running}, 0);

        // Reset mid-debounce with the run button still held.
        tick(1, 1, 0, 0);
        tick(1, 1, 0, 0);
        tick(0, 1, 0, 0);
        tick(0, 1, 0, 0);
        for (int i = 0; i < 10; i++) begin
            tick(1, 1, 0, 0);
            if (i == DC)     chk("rst_mid_pre",  {31'b0, running}, 0);
            if (i == DC + 1) chk("rst_mid_post", {31'b0, running}, 1);
        end
        for (int i = 0; i < 8; i++) tick(1, 0, 0, 0);

        // Random button activity with varied hold times and rare resets.
        for (int b = 0; b < 3; b++) begin hold[b] = 0; lvl[b] = 1'b0; end
        for (int i = 0; i < 2000; i++) begin
            for (int b = 0; b < 3; b++) begin
                if (hold[b] == 0) begin
                    lvl[b]  = $urandom_range(0, 1) == 1;
                    hold[b] = $urandom_range(1, 12);
                end
                hold[b]--;
            end
            tick(($urandom_range(0, 199) != 0), lvl[0], lvl[1], lvl[2]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
